// File: rtl/prog_loader_4bit_if.sv
// Record stream between a program source and the loader.
// master drives records; slave (the loader) returns in_ready.
interface prog_loader_4bit_if;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_ins;
   logic [3:0] in_data;
   logic       in_last;

   modport master (output in_valid, output in_ins, output in_data, output in_last, input in_ready);
   modport slave  (input in_valid, input in_ins, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/prog_loader_4bit.sv
// Loads program records into computer_4bit memories while holding the CPU in reset.
// Optional LOADER_CHECKSUM_EN: a trailing checksum record must zero the 8-bit sum of all instructions.
module prog_loader_4bit #(
   parameter int DEPTH      = 16,
   parameter int SETTLE_CYC = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   prog_loader_4bit_if.slave            rec,
   output logic [$clog2(DEPTH)-1:0]     ins_address,
   output logic [7:0]                   ins,
   output logic [3:0]                   d_in,
   output logic                         ld_we,
   output logic                         cpu_rst,
   output logic                         busy,
   output logic                         done,
   output logic                         err,
   output logic [$clog2(DEPTH+1)-1:0]   load_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = $clog2(SETTLE_CYC) + 1;
   localparam logic [CW-1:0] LAST_SLOT   = CW'(DEPTH - 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_RUN, S_ERROR} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] load_count_q, load_count_d;
   logic [SW-1:0] settle_q, settle_d;
   logic [AW-1:0] ins_address_q, ins_address_d;
   logic [7:0]    ins_q, ins_d;
   logic [3:0]    d_in_q, d_in_d;
   logic          ld_we_q, ld_we_d;
   logic          accept;
   logic          do_write;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]    sum_q, sum_d;
   logic          got_last_q, got_last_d;
   logic [7:0]    cs_total;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         load_count_q  <= '0;
         settle_q      <= '0;
         ins_address_q <= '0;
         ins_q         <= '0;
         d_in_q        <= '0;
         ld_we_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         sum_q         <= '0;
         got_last_q    <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         load_count_q  <= load_count_d;
         settle_q      <= settle_d;
         ins_address_q <= ins_address_d;
         ins_q         <= ins_d;
         d_in_q        <= d_in_d;
         ld_we_q       <= ld_we_d;
`ifdef LOADER_CHECKSUM_EN
         sum_q         <= sum_d;
         got_last_q    <= got_last_d;
`endif
      end
   end

   always_comb begin
      state_d       = state_q;
      load_count_d  = load_count_q;
      settle_d      = settle_q;
      ins_address_d = ins_address_q;
      ins_d         = ins_q;
      d_in_d        = d_in_q;
      ld_we_d       = 1'b0;
      do_write      = 1'b0;
      accept        = rec.in_valid && (state_q == S_LOAD);
`ifdef LOADER_CHECKSUM_EN
      sum_d         = sum_q;
      got_last_d    = got_last_q;
      cs_total      = sum_q + rec.in_ins;
`endif
      case (state_q)
         S_IDLE, S_RUN, S_ERROR: begin
            if (start) begin
               state_d      = S_LOAD;
               load_count_d = '0;
               settle_d     = '0;
`ifdef LOADER_CHECKSUM_EN
               sum_d        = '0;
               got_last_d   = 1'b0;
`endif
            end
         end
         S_LOAD: begin
            if (accept) begin
`ifdef LOADER_CHECKSUM_EN
               // The record after in_last carries the checksum and is never written.
               if (got_last_q) begin
                  state_d = (cs_total == 8'h00) ? S_SETTLE : S_ERROR;
               end else begin
                  do_write = 1'b1;
                  if (rec.in_last) begin
                     got_last_d = 1'b1;
                  end else if (load_count_q == LAST_SLOT) begin
                     state_d = S_ERROR;
                  end
               end
`else
               do_write = 1'b1;
               if (rec.in_last) begin
                  state_d = S_SETTLE;
               end else if (load_count_q == LAST_SLOT) begin
                  state_d = S_ERROR;
               end
`endif
            end
         end
         S_SETTLE: begin
            if (settle_q == SETTLE_LAST) begin
               state_d = S_RUN;
            end else begin
               settle_d = settle_q + SW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (do_write) begin
         ld_we_d       = 1'b1;
         ins_address_d = load_count_q[AW-1:0];
         ins_d         = rec.in_ins;
         d_in_d        = rec.in_data;
         load_count_d  = load_count_q + CW'(1);
`ifdef LOADER_CHECKSUM_EN
         sum_d         = sum_q + rec.in_ins;
`endif
      end
   end

   assign rec.in_ready = (state_q == S_LOAD);
   assign cpu_rst      = (state_q != S_RUN);
   assign busy         = (state_q == S_LOAD) || (state_q == S_SETTLE);
   assign done         = (state_q == S_RUN);
   assign err          = (state_q == S_ERROR);
   assign ins_address  = ins_address_q;
   assign ins          = ins_q;
   assign d_in         = d_in_q;
   assign ld_we        = ld_we_q;
   assign load_count   = load_count_q;
endmodule
